// File: rtl/mult_feeder.sv
// rtl/mult_feeder.sv - operand FIFO and sequencer feeding a shift-add multiplier
module mult_feeder #(
  parameter int W     = 4,
  parameter int DEPTH = 4,
  parameter int STEPS = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic           mul_e,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic [2*W-1:0] mul_c,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [2*W-1:0] res_c,
  output logic           busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CLEAR   = 2'd1,
    S_RUN     = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  // Operand FIFO storage and bookkeeping
  logic [2*W-1:0] mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q,  count_d;

  // Sequencer and result registers
  state_t         state_q;
  logic [SW-1:0]  step_q;
  logic           mul_e_q;
  logic           busy_q;
  logic [W-1:0]   mul_a_q;
  logic [W-1:0]   mul_b_q;
  logic           res_valid_q;
  logic [2*W-1:0] res_c_q;

  logic push;
  logic start;

  // Readiness comes from the registered count only, so a full FIFO never
  // accepts in the same cycle it pops.
  assign in_ready = (count_q != CW'(DEPTH));
  assign push     = in_valid && in_ready;

  // A new multiply starts only when the result register will be free by the
  // time CAPTURE arrives: either empty now or being consumed this edge.
  assign start = (state_q == S_IDLE) && (count_q != '0) &&
                 (!res_valid_q || res_ready);

  assign mul_e     = mul_e_q;
  assign busy      = busy_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign res_valid = res_valid_q;
  assign res_c     = res_c_q;

  // Next-state for FIFO pointers and occupancy; pointers wrap on power-of-2 depth
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (start) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, start})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointer and count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO data array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_a, in_b};
    end
  end

  // Sequencer: IDLE -> CLEAR (multiplier cleared) -> RUN x STEPS -> CAPTURE.
  // mul_e and busy are registered alongside the state so they follow it exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      mul_e_q <= 1'b0;
      busy_q  <= 1'b0;
      mul_a_q <= '0;
      mul_b_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            {mul_a_q, mul_b_q} <= mem_q[rd_ptr_q];
            state_q <= S_CLEAR;
            busy_q  <= 1'b1;
            mul_e_q <= 1'b0;
          end
        end
        S_CLEAR: begin
          step_q  <= '0;
          state_q <= S_RUN;
          mul_e_q <= 1'b1;
        end
        S_RUN: begin
          if (step_q == SW'(STEPS - 1)) begin
            step_q  <= '0;
            state_q <= S_CAPTURE;
            mul_e_q <= 1'b0;
          end else begin
            step_q <= step_q + SW'(1);
          end
        end
        S_CAPTURE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          mul_e_q <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          mul_e_q <= 1'b0;
        end
      endcase
    end
  end

  // Result register: load on CAPTURE, release when the consumer takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_c_q     <= '0;
    end else if (state_q == S_CAPTURE) begin
      res_valid_q <= 1'b1;
      res_c_q     <= mul_c;
    end else if (res_valid_q && res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

endmodule
